// File: rtl/lut4ab_cfg_pkg.sv
// Shared LUT4AB slice configuration: ConfigBits field positions and small helpers.
package lut4ab_cfg_pkg;

  localparam int NoConfigBits = 20;

  localparam int CFG_INIT_LSB = 0;
  localparam int CFG_OUT_MUX  = 16;
  localparam int CFG_I0MUX    = 17;
  localparam int CFG_RST_VAL  = 18;
  localparam int CFG_SRL      = 19;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/cus_mux21.sv
// Custom 2:1 mux cell; every slice selection is built from this so it maps to one cell type.
module cus_mux21 (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);

  assign X = S ? A1 : A0;

endmodule

// File: rtl/srl16_store.sv
// 16-bit truth-table storage: INIT in LUT mode, user shift register in SRL mode.
// Reset reloads INIT asynchronously; read is a 16:1 mux tree, 0-cycle, pre-shift contents.
module srl16_store (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] init_i,
  input  logic        srl_mode_i,
  input  logic        we_i,
  input  logic        si_i,
  input  logic [3:0]  addr_i,
  output logic        rd_o,
  output logic        so_o
);

  logic [15:0] srl_q;
  logic [15:0] srl_d;
  logic [15:0] shift_w;
  logic [15:0] shift_sel_w;
  logic [15:0] rd_src_w;
  logic [7:0]  lvl1_w;
  logic [3:0]  lvl2_w;
  logic [1:0]  lvl3_w;

  assign shift_w = {srl_q[14:0], si_i};

  // In LUT mode the store tracks INIT so SO stays meaningful and WE/SI are ignored.
  for (genvar k = 0; k < 16; k++) begin : g_bit
    cus_mux21 u_we   (.A0(srl_q[k]),  .A1(shift_w[k]),     .S(we_i),       .X(shift_sel_w[k]));
    cus_mux21 u_mode (.A0(init_i[k]), .A1(shift_sel_w[k]), .S(srl_mode_i), .X(srl_d[k]));
    cus_mux21 u_src  (.A0(init_i[k]), .A1(srl_q[k]),       .S(srl_mode_i), .X(rd_src_w[k]));
  end

  for (genvar j = 0; j < 8; j++) begin : g_l1
    cus_mux21 u_m (.A0(rd_src_w[2*j]), .A1(rd_src_w[2*j+1]), .S(addr_i[0]), .X(lvl1_w[j]));
  end
  for (genvar j = 0; j < 4; j++) begin : g_l2
    cus_mux21 u_m (.A0(lvl1_w[2*j]), .A1(lvl1_w[2*j+1]), .S(addr_i[1]), .X(lvl2_w[j]));
  end
  for (genvar j = 0; j < 2; j++) begin : g_l3
    cus_mux21 u_m (.A0(lvl2_w[2*j]), .A1(lvl2_w[2*j+1]), .S(addr_i[2]), .X(lvl3_w[j]));
  end
  cus_mux21 u_l4 (.A0(lvl3_w[0]), .A1(lvl3_w[1]), .S(addr_i[3]), .X(rd_o));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      srl_q <= init_i;
    end else begin
      srl_q <= srl_d;
    end
  end

  assign so_o = srl_q[15];

endmodule

// File: rtl/lut4_srl_frame_config.sv
// LUT4 slice with SRL16 mode, majority carry and optional output flop.
// O/Co combinational (0 cycles) or O registered (1 cycle with EN); no backpressure.
module lut4_srl_frame_config #(
  parameter int NoConfigBits = 20
) (
  input  logic                    UserCLK,
  input  logic                    RST,
  input  logic [3:0]              I,
  input  logic                    Ci,
  input  logic                    SR,
  input  logic                    EN,
  input  logic                    WE,
  input  logic                    SI,
  output logic                    O,
  output logic                    Co,
  output logic                    SO,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  import lut4ab_cfg_pkg::*;

  logic i0_w;
  logic lut_w;
  logic en_w;
  logic q_d;
  logic q_q;

  cus_mux21 u_i0 (.A0(I[0]), .A1(Ci), .S(ConfigBits[CFG_I0MUX]), .X(i0_w));

  srl16_store u_store (
    .clk_i      (UserCLK),
    .rst_i      (RST),
    .init_i     (ConfigBits[CFG_INIT_LSB +: 16]),
    .srl_mode_i (ConfigBits[CFG_SRL]),
    .we_i       (WE),
    .si_i       (SI),
    .addr_i     ({I[3:1], i0_w}),
    .rd_o       (lut_w),
    .so_o       (SO)
  );

  assign Co = maj3(Ci, I[1], I[2]);

  // SR is the outer mux so it overrides EN.
  cus_mux21 u_en (.A0(q_q),  .A1(lut_w),                   .S(EN), .X(en_w));
  cus_mux21 u_sr (.A0(en_w), .A1(ConfigBits[CFG_RST_VAL]), .S(SR), .X(q_d));

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      q_q <= ConfigBits[CFG_RST_VAL];
    end else begin
      q_q <= q_d;
    end
  end

  cus_mux21 u_o (.A0(lut_w), .A1(q_q), .S(ConfigBits[CFG_OUT_MUX]), .X(O));

endmodule

// File: tb/tb_lut4_srl_frame_config.sv
// Directed plus randomized bench for lut4_srl_frame_config against a behavioural slice model.
module tb_lut4_srl_frame_config;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  I = '0;
  logic        Ci = 1'b0;
  logic        SR = 1'b0;
  logic        EN = 1'b0;
  logic        WE = 1'b0;
  logic        SI = 1'b0;
  logic        O;
  logic        Co;
  logic        SO;
  logic [19:0] cfg = '0;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [15:0] m_srl;
  logic        m_q;

  lut4_srl_frame_config #(.NoConfigBits(20)) dut (
    .UserCLK    (clk),
    .RST        (RST),
    .I          (I),
    .Ci         (Ci),
    .SR         (SR),
    .EN         (EN),
    .WE         (WE),
    .SI         (SI),
    .O          (O),
    .Co         (Co),
    .SO         (SO),
    .ConfigBits (cfg)
  );

  always #5 clk = ~clk;

  function automatic logic m_lut();
    int idx;
    idx = {I[3:1], (cfg[17] ? Ci : I[0])};
    return cfg[19] ? m_srl[idx] : cfg[idx];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_o;
    exp_o = cfg[16] ? m_q : m_lut();
    chk({tag, ".O"}, O, exp_o);
    chk({tag, ".Co"}, Co, ($countones({Ci, I[1], I[2]}) >= 2));
    chk({tag, ".SO"}, SO, m_srl[15]);
  endtask

  // One rising edge; the model samples the inputs that were stable before it.
  task automatic step();
    logic lut;
    @(posedge clk);
    if (!RST) begin
      lut = m_lut();
      if (SR) m_q = cfg[18];
      else if (EN) m_q = lut;
      if (cfg[19] && WE) m_srl = {m_srl[14:0], SI};
    end
    #1;
  endtask

  task automatic do_reset(input logic [19:0] new_cfg);
    cfg = new_cfg;
    SR = 1'b0; EN = 1'b0; WE = 1'b0; SI = 1'b0;
    RST = 1'b1;
    m_srl = new_cfg[15:0];
    m_q = new_cfg[18];
    #1;
    check_outputs("reset");
    @(negedge clk);
    RST = 1'b0;
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] init;

    // LUT mode, AND-of-all-inputs truth table, combinational output
    do_reset({4'b0000, 16'h8000});
    for (int v = 0; v < 32; v++) begin
      {Ci, I} = v[4:0];
      #1;
      chk("lut8000.O", O, (I == 4'hF));
      check_outputs("lut8000");
    end

    // Ci replaces I[0]
    do_reset({4'b0010, 16'hAAAA});
    I = 4'h0;
    for (int t = 0; t < 4; t++) begin
      Ci = t[0];
      #1;
      chk("i0mux.O", O, t[0]);
      check_outputs("i0mux");
    end

    // SRL mode: shift in C3A5 MSB first
    do_reset({4'b1000, 16'h0000});
    pat = 16'hC3A5;
    WE = 1'b1;
    for (int b = 15; b >= 0; b--) begin
      SI = pat[b];
      step();
      check_outputs("srl_shift");
    end
    WE = 1'b0;
    I = 4'h0; #1; chk("srl.I0", O, 1'b1);
    I = 4'h1; #1; chk("srl.I1", O, 1'b0);
    I = 4'hF; #1; chk("srl.IF", O, 1'b1);
    check_outputs("srl_read");

    // Registered output, reset value 1
    do_reset({4'b0101, 16'h0001});
    chk("reg.rst_O", O, 1'b1);
    I = 4'h1; EN = 1'b1;
    step(); chk("reg.en_O", O, 1'b0);
    SR = 1'b1;
    step(); chk("reg.sr_O", O, 1'b1);
    SR = 1'b0; I = 4'h1;
    step(); chk("reg.en2_O", O, 1'b0);
    EN = 1'b0; I = 4'h0;
    step(); chk("reg.hold_O", O, 1'b0);
    check_outputs("reg");

    // Reset pulse mid-shift
    init = 16'h9C3B;
    do_reset({4'b1000, init});
    WE = 1'b1;
    for (int s = 0; s < 7; s++) begin
      SI = 1'($urandom_range(0, 1));
      step();
      check_outputs("midshift");
    end
    SI = ~init[14];
    EN = 1'b1;
    RST = 1'b1;
    m_srl = init;
    m_q = cfg[18];
    #1;
    chk("rstpulse.SO", SO, init[15]);
    for (int a = 0; a < 16; a++) begin
      I = a[3:0];
      #1;
      chk("rstpulse.O", O, init[a]);
    end
    step();
    chk("rst_edge.SO", SO, init[15]);
    for (int a = 0; a < 16; a++) begin
      I = a[3:0];
      #1;
      check_outputs("rst_edge");
    end
    @(negedge clk);
    RST = 1'b0;
    WE = 1'b0; EN = 1'b0;
    #1;
    check_outputs("rst_release");

    // Same-edge shift and capture, registered SRL mode
    do_reset({4'b1001, 16'h0008});
    I = 4'h3; SI = 1'b0; WE = 1'b1; EN = 1'b1;
    step(); chk("same_edge.O", O, 1'b1);
    WE = 1'b0;
    step(); chk("post_shift.O", O, 1'b0);
    check_outputs("same_edge");

    // Randomized traffic across random configurations
    for (int c = 0; c < 8; c++) begin
      do_reset(20'($urandom));
      for (int n = 0; n < 150; n++) begin
        I  = 4'($urandom);
        Ci = 1'($urandom);
        SR = ($urandom_range(0, 9) == 0);
        EN = 1'($urandom);
        WE = 1'($urandom);
        SI = 1'($urandom);
        #1;
        check_outputs("rand_comb");
        step();
        check_outputs("rand_edge");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lut4_srl_frame_config.md
# lut4_srl_frame_config

Frame-configured 4-input LUT slice with an optional 16-bit shift-register (SRL16) mode and an output flip-flop. Eight instances per LUT4AB tile drive the A..H inputs of the tile's 8:1 wide-function mux stage. The mode and truth table are static configuration from `ConfigBits`. In SRL mode the truth-table storage becomes a user-writable shift register, clocked by the fabric user clock.

## Interface
Parameters:
- `NoConfigBits`, 20 — width of `ConfigBits`; fixed at 20, no arithmetic derivation.

Ports:
- `UserCLK` in 1 — fabric user clock; all state updates on rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `I` in 4 — LUT address inputs `I[3:0]`.
- `Ci` in 1 — carry-in from the previous slice.
- `SR` in 1 — synchronous set/reset of the output flop.
- `EN` in 1 — output flop clock enable.
- `WE` in 1 — shift enable; effective only in SRL mode.
- `SI` in 1 — shift-register serial input.
- `O` out 1 — slice output to the mux stage; combinational or registered per config.
- `Co` out 1 — carry-out to the next slice.
- `SO` out 1 — serial out (`srl[15]`) for cascading SRLs.
- `ConfigBits` in 20 — GLOBAL, frame config:
  - `[15:0]` INIT / truth table.
  - `[16]` c_out_mux: 1 = registered `O`.
  - `[17]` c_I0mux: 1 = `Ci` replaces `I[0]`.
  - `[18]` c_reset_value: `Q` value applied on `SR`/`RST`.
  - `[19]` c_srl: 1 = SRL mode.

## Operation
- Effective address `idx = {I[3], I[2], I[1], i0}`, where `i0 = c_I0mux ? Ci : I[0]`.
- LUT mode (c_srl=0):
  - `lut_out = ConfigBits[idx]`.
  - Internal `srl[15:0]` holds `ConfigBits[15:0]` and ignores `WE`/`SI`.
- SRL mode (c_srl=1):
  - `lut_out = srl[idx]`.
  - On a clock edge with `WE=1`: `srl <= {srl[14:0], SI}`.
  - On a clock edge with `WE=0`: `srl` holds.
- `SO = srl[15]` in both modes.
- Carry: `Co = (Ci & I[1]) | (Ci & I[2]) | (I[1] & I[2])`. Independent of mode and of c_I0mux.
- Output flop `Q`, priority on each edge:
  - `SR=1` → `Q <= c_reset_value`.
  - Else `EN=1` → `Q <= lut_out`.
  - Else hold.
  - `SR` overrides `EN`.
- `O = c_out_mux ? Q : lut_out`.
- Reset (`RST=1`, asynchronous, dominates all inputs):
  - `Q = c_reset_value`.
  - `srl = ConfigBits[15:0]`.
  - `O` = `c_reset_value` if registered, otherwise the combinational LUT value of INIT.
  - `SO = ConfigBits[15]`.
- Reset during shifting: partially shifted contents are discarded and reloaded from INIT. No edge is processed while `RST` is high.
- Changing c_srl while running is not supported. After any config load, `RST` must be asserted before use.

## Timing
- `I`/`Ci` → `O` (combinational mode): 0 cycles.
- `I`/`Ci` → `Co`: 0 cycles.
- `I` → `O` (registered mode): 1 cycle, when `EN=1`.
- Shift visibility:
  - The `lut_out`/`O` read in the cycle of a shift returns pre-shift contents.
  - New contents are visible after the edge.
  - Registered `O` reflects a shifted bit 2 edges after `SI` is sampled.
- `WE` and `EN` on the same edge: `Q` captures the pre-shift `lut_out`, and `srl` shifts.
- Reset release: the first active edge is the first `UserCLK` rising edge after `RST` deasserts. The environment synchronises deassertion.

## Structure
- Shared package `lut4ab_cfg_pkg` holds:
  - Config bit index constants: `CFG_INIT_LSB=0`, `CFG_OUT_MUX=16`, `CFG_I0MUX=17`, `CFG_RST_VAL=18`, `CFG_SRL=19`.
  - `NoConfigBits=20`.
- One sub-module `srl16_store`:
  - Holds the 16-bit storage with async INIT reload, shift, and a 16:1 read mux built from `cus_mux21` cells.
  - The top level contains `i0` selection, carry, the output flop and the `O` select.
- All 2:1 selections use `cus_mux21` instances.

## Test plan
- LUT mode, INIT=16'h8000, c_out_mux=0: sweep `I` 0..15 → `O=1` only at `I=4'hF`; `Co` matches the majority of `Ci`, `I[1]`, `I[2]` for all 32 combinations.
- c_I0mux=1, INIT=16'hAAAA, `I[0]=0`, toggle `Ci` → `O` follows `Ci` combinationally.
- SRL mode, INIT=0, shift in 16 bits of 16'hC3A5 (MSB first, `WE=1`) → `SO` shows the shifted stream; then `I=4'h0` → `O=1`, `I=4'h1` → `O=0`, `I=4'hF` → `O=1`.
- Registered mode, c_reset_value=1: `EN=1` with `lut_out=0` → `O=0` after 1 edge; `SR=1` with `EN=1` → `O=1`; `EN=0` → hold.
- Pulse `RST` mid-shift (after 7 shifts, between edges) → immediately `srl=INIT`, `Q=c_reset_value`, `SO=INIT[15]`; no change on the edge coincident with `RST` high.
- Same-edge `WE=1`, `EN=1`, registered mode → `Q` holds the pre-shift bit at `idx`; the next read shows the shifted value.
